// File: rtl/auto_tiling_weight_gen.sv
// Weight-tile SRAM read-address generator: one address per lane per beat, tiles of LANES columns, optional diagonal skew.
// First beat is registered one edge after an accepted start; counters advance only on io_beatValid && io_ready, and all beat outputs hold while stalled.
module auto_tiling_weight_gen #(
   parameter int LANES  = 16,
   parameter int ADDR_W = 17,
   parameter int DIM_W  = 12
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_start,
   input  logic [DIM_W-1:0]          io_cfgK,
   input  logic [DIM_W-1:0]          io_cfgM,
   input  logic                      io_cfgSkew,
   input  logic                      io_ready,
   output logic                      io_beatValid,
   output logic [LANES*ADDR_W-1:0]   io_rdAddr,
   output logic [LANES-1:0]          io_addrValid,
   output logic [DIM_W-1:0]          io_tileIdx,
   output logic                      io_busy,
   output logic                      io_done,
   output logic                      io_cfgErr
);
   // Beat and column counters must reach K+LANES-2 and M+LANES-1 respectively.
   localparam int CW = DIM_W + $clog2(LANES + 1);
   localparam int PW = (2 * DIM_W > ADDR_W + 1) ? 2 * DIM_W : ADDR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                    state_q, state_d;
   logic [DIM_W-1:0]          k_q, k_d, m_q, m_d, tile_q, tile_d;
   logic                      skew_q, skew_d;
   logic [CW-1:0]             bmax_q, bmax_d, beat_q, beat_d, col_q, col_d;
   logic [ADDR_W-1:0]         row_q, row_d;
   logic                      vld_q, vld_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic [LANES*ADDR_W-1:0]   addr_q, addr_d;
   logic [LANES-1:0]          mask_q, mask_d;
   logic [PW-1:0]             km;
   logic                      cfg_bad, accept;

   assign km      = PW'(io_cfgK) * PW'(io_cfgM);
   assign cfg_bad = (io_cfgK == '0) || (io_cfgM == '0) || (km > (PW'(1) << ADDR_W));
   assign accept  = vld_q && io_ready;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      m_d     = m_q;
      skew_d  = skew_q;
      bmax_d  = bmax_q;
      beat_d  = beat_q;
      col_d   = col_q;
      row_d   = row_q;
      tile_d  = tile_q;
      vld_d   = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (io_start) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  state_d = S_RUN;
                  k_d     = io_cfgK;
                  m_d     = io_cfgM;
                  skew_d  = io_cfgSkew;
                  bmax_d  = CW'(io_cfgK) + (io_cfgSkew ? CW'(LANES - 1) : '0) - CW'(1);
                  beat_d  = '0;
                  col_d   = '0;
                  row_d   = '0;
                  tile_d  = '0;
                  vld_d   = 1'b1;
                  busy_d  = 1'b1;
               end
            end
         end
         S_RUN: begin
            vld_d  = 1'b1;
            busy_d = 1'b1;
            if (accept) begin
               if (beat_q == bmax_q) begin
                  if (col_q + CW'(LANES) >= CW'(m_q)) begin
                     state_d = S_DONE;
                     vld_d   = 1'b0;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end else begin
                     tile_d = tile_q + DIM_W'(1);
                     col_d  = col_q + CW'(LANES);
                     beat_d = '0;
                     row_d  = ADDR_W'(col_q + CW'(LANES));
                  end
               end else begin
                  beat_d = beat_q + CW'(1);
                  row_d  = row_q + ADDR_W'(m_q);
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // row_d = beat*M + tile column base, kept modulo 2^ADDR_W; legal configs keep every valid address in range.
   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [CW-1:0]     col_j, row_j;
      logic [ADDR_W-1:0] a_j;
      logic              v_j;
      assign col_j = col_d + CW'(j);
      assign row_j = beat_d - (skew_d ? CW'(j) : '0);
      assign v_j   = vld_d && (!skew_d || beat_d >= CW'(j)) && (row_j < CW'(k_d)) && (col_j < CW'(m_d));
      assign a_j   = row_d + ADDR_W'(j) - (skew_d ? ADDR_W'(j) * ADDR_W'(m_d) : '0);
      assign mask_d[j]                   = v_j;
      assign addr_d[j*ADDR_W +: ADDR_W]  = v_j ? a_j : '0;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         m_q     <= '0;
         skew_q  <= 1'b0;
         bmax_q  <= '0;
         beat_q  <= '0;
         col_q   <= '0;
         row_q   <= '0;
         tile_q  <= '0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         m_q     <= m_d;
         skew_q  <= skew_d;
         bmax_q  <= bmax_d;
         beat_q  <= beat_d;
         col_q   <= col_d;
         row_q   <= row_d;
         tile_q  <= tile_d;
         vld_q   <= vld_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         mask_q  <= mask_d;
      end
   end

   assign io_beatValid = vld_q;
   assign io_rdAddr    = addr_q;
   assign io_addrValid = mask_q;
   assign io_tileIdx   = tile_q;
   assign io_busy      = busy_q;
   assign io_done      = done_q;
   assign io_cfgErr    = err_q;
endmodule

// File: tb/tb_auto_tiling_weight_gen.sv
// Directed bench for auto_tiling_weight_gen: spec-derived lane model plus hand-computed spot values.
module tb_auto_tiling_weight_gen;
   localparam int LN = 16;
   localparam int AW = 17;
   localparam int DW = 12;

   logic              clock, reset, io_start, io_cfgSkew, io_ready;
   logic [DW-1:0]     io_cfgK, io_cfgM, io_tileIdx;
   logic              io_beatValid, io_busy, io_done, io_cfgErr;
   logic [LN*AW-1:0]  io_rdAddr;
   logic [LN-1:0]     io_addrValid;

   int n_chk = 0;
   int n_err = 0;
   logic [LN*AW-1:0] acc_q[$];
   logic [LN*AW-1:0] ref_q[$];
   logic [LN-1:0]    mk_q[$];

   auto_tiling_weight_gen #(.LANES(LN), .ADDR_W(AW), .DIM_W(DW)) dut (
      .clock(clock), .reset(reset), .io_start(io_start), .io_cfgK(io_cfgK), .io_cfgM(io_cfgM),
      .io_cfgSkew(io_cfgSkew), .io_ready(io_ready), .io_beatValid(io_beatValid), .io_rdAddr(io_rdAddr),
      .io_addrValid(io_addrValid), .io_tileIdx(io_tileIdx), .io_busy(io_busy), .io_done(io_done),
      .io_cfgErr(io_cfgErr));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [AW-1:0] lane_of(input logic [LN*AW-1:0] vec, input int j);
      return vec[j*AW +: AW];
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_vld"}, 32'(io_beatValid), 0);
      chk({tag, "_addr"}, 32'(|io_rdAddr), 0);
      chk({tag, "_mask"}, 32'(io_addrValid), 0);
      chk({tag, "_tile"}, 32'(io_tileIdx), 0);
      chk({tag, "_busy"}, 32'(io_busy), 0);
      chk({tag, "_done"}, 32'(io_done), 0);
      chk({tag, "_err"}, 32'(io_cfgErr), 0);
   endtask

   // Runs a job from an IDLE negedge; stop_at >= 0 abandons it after that many accepts.
   task automatic run_job(input int K, input int M, input int sk, input bit rnd,
                          input int stop_at, input bit poke, output int accepts);
      int T, B, t, b, cyc, total, k, col;
      bit r;
      logic [LN-1:0] emask;
      logic [31:0] ea;
      T = (M + LN - 1) / LN;
      B = sk ? K + LN - 1 : K;
      total = T * B;
      t = 0; b = 0; cyc = 0; accepts = 0;
      acc_q.delete(); mk_q.delete();
      io_start = 1'b1; io_cfgK = DW'(K); io_cfgM = DW'(M); io_cfgSkew = (sk != 0); io_ready = 1'b1;
      @(negedge clock);
      io_start = 1'b0;
      while (accepts < total) begin
         if (cyc > 20000) begin
            chk("timeout_accepts", 32'(accepts), 32'(total));
            break;
         end
         if (stop_at >= 0 && accepts == stop_at) return;
         chk("beat_vld", 32'(io_beatValid), 1);
         chk("beat_busy", 32'(io_busy), 1);
         chk("beat_done", 32'(io_done), 0);
         chk("beat_err", 32'(io_cfgErr), 0);
         chk("beat_tile", 32'(io_tileIdx), 32'(t));
         emask = '0;
         for (int j = 0; j < LN; j++) begin
            k = b - (sk ? j : 0);
            col = t * LN + j;
            emask[j] = (k >= 0 && k < K && col < M);
            ea = emask[j] ? 32'(k * M + col) : 32'd0;
            chk("beat_addr", 32'(lane_of(io_rdAddr, j)), ea);
         end
         chk("beat_mask", 32'(io_addrValid), 32'(emask));
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         io_ready = r;
         if (poke) begin
            io_start = (cyc == 1);
            io_cfgK  = (cyc == 1) ? '0 : DW'(K);
         end
         if (r) begin
            acc_q.push_back(io_rdAddr);
            mk_q.push_back(io_addrValid);
         end
         @(negedge clock);
         cyc++;
         if (r) begin
            accepts++;
            if (b == B - 1) begin b = 0; t++; end
            else b++;
         end
      end
      io_start = 1'b0; io_ready = 1'b1;
      chk("end_done", 32'(io_done), 1);
      chk("end_vld", 32'(io_beatValid), 0);
      chk("end_busy", 32'(io_busy), 0);
      chk("end_mask", 32'(io_addrValid), 0);
      @(negedge clock);
      chk("idle_done", 32'(io_done), 0);
      chk("idle_vld", 32'(io_beatValid), 0);
      chk("idle_busy", 32'(io_busy), 0);
   endtask

   task automatic bad_start(input string tag, input int K, input int M);
      io_start = 1'b1; io_cfgK = DW'(K); io_cfgM = DW'(M); io_cfgSkew = 1'b0;
      @(negedge clock);
      io_start = 1'b0;
      chk({tag, "_err"}, 32'(io_cfgErr), 1);
      chk({tag, "_busy"}, 32'(io_busy), 0);
      chk({tag, "_vld"}, 32'(io_beatValid), 0);
      @(negedge clock);
      chk({tag, "_err_clr"}, 32'(io_cfgErr), 0);
      chk({tag, "_busy2"}, 32'(io_busy), 0);
   endtask

   initial begin
      int n;
      reset = 1'b1; io_start = 1'b0; io_cfgK = '0; io_cfgM = '0; io_cfgSkew = 1'b0; io_ready = 1'b0;
      @(negedge clock);
      @(negedge clock);
      chk_idle("rst");
      reset = 1'b0;
      @(negedge clock);
      chk_idle("rst_rel");

      run_job(147, 64, 0, 1'b0, -1, 1'b0, n);
      chk("s1_accepts", 32'(n), 588);
      chk("s1_beats", 32'(acc_q.size()), 588);
      for (int j = 0; j < LN; j++) chk("s1_b0_lane", 32'(lane_of(acc_q[0], j)), 32'(j));
      chk("s1_t1b2_l3", 32'(lane_of(acc_q[149], 3)), 147);
      chk("s1_last_l15", 32'(lane_of(acc_q[587], 15)), 9407);
      chk("s1_mask_first", 32'(mk_q[0]), 32'h0000FFFF);
      chk("s1_mask_last", 32'(mk_q[587]), 32'h0000FFFF);
      ref_q = acc_q;

      run_job(4, 20, 0, 1'b0, -1, 1'b1, n);
      chk("s2_beats", 32'(n), 8);
      chk("s2_t1_mask", 32'(mk_q[4]), 32'h0000000F);
      chk("s2_t1b3_l0", 32'(lane_of(acc_q[7], 0)), 76);

      run_job(3, 16, 1, 1'b0, -1, 1'b0, n);
      chk("s3_beats", 32'(n), 18);
      chk("s3_b0_mask", 32'(mk_q[0]), 32'h00000001);
      chk("s3_b0_l0", 32'(lane_of(acc_q[0], 0)), 0);
      chk("s3_b2_mask", 32'(mk_q[2]), 32'h00000007);
      chk("s3_b2_l0", 32'(lane_of(acc_q[2], 0)), 32);
      chk("s3_b2_l1", 32'(lane_of(acc_q[2], 1)), 17);
      chk("s3_b2_l2", 32'(lane_of(acc_q[2], 2)), 2);
      chk("s3_b17_mask", 32'(mk_q[17]), 32'h00008000);
      chk("s3_b17_l15", 32'(lane_of(acc_q[17], 15)), 47);

      run_job(147, 64, 0, 1'b1, -1, 1'b0, n);
      chk("bp_accepts", 32'(n), 588);
      chk("bp_beats", 32'(acc_q.size()), 588);
      if (acc_q.size() == 588 && ref_q.size() == 588) begin
         for (int i = 0; i < 588; i++) chk("bp_seq_match", 32'(acc_q[i] == ref_q[i]), 1);
      end
      chk("bp_last_l15", 32'(lane_of(acc_q[acc_q.size() - 1], 15)), 9407);

      bad_start("k0", 0, 64);
      bad_start("m0", 4, 0);
      bad_start("big", 4095, 4095);
      bad_start("over", 64, 2049);
      io_start = 1'b1; io_cfgK = DW'(64); io_cfgM = DW'(2048); io_cfgSkew = 1'b0;
      @(negedge clock);
      io_start = 1'b0;
      chk("limit_err", 32'(io_cfgErr), 0);
      chk("limit_busy", 32'(io_busy), 1);
      chk("limit_mask", 32'(io_addrValid), 32'h0000FFFF);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      run_job(147, 64, 0, 1'b0, 100, 1'b0, n);
      chk("mid_accepts", 32'(n), 100);
      chk("mid_b100_l0", 32'(lane_of(io_rdAddr, 0)), 6400);
      reset = 1'b1;
      #1;
      chk_idle("mid_rst");
      @(negedge clock);
      chk_idle("mid_rst_hold");
      reset = 1'b0;
      @(negedge clock);
      chk_idle("mid_rel");
      run_job(147, 64, 0, 1'b0, -1, 1'b0, n);
      chk("re_accepts", 32'(n), 588);
      chk("re_b0_l7", 32'(lane_of(acc_q[0], 7)), 7);
      chk("re_t1b2_l3", 32'(lane_of(acc_q[149], 3)), 147);
      chk("re_last_l15", 32'(lane_of(acc_q[587], 15)), 9407);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/auto_tiling_weight_gen.md
# auto_tiling_weight_gen

Parametrised weight-tile read-address generator for the systolic array's weight feed path. It replaces the fixed 16-lane generator. Lane count, address width and matrix dimensions are parameters or run-time configuration. It adds a ready/valid backpressure handshake, start/done control, configuration checking, and an optional diagonal-skew mode that pre-staggers lanes for direct systolic injection. It sits between the controller and the weight SRAM read ports: one address per lane per beat, with a per-lane valid mask.

## Interface
Parameters:
- LANES, 16, number of array columns / read lanes
- ADDR_W, 17, byte address width into the weight buffer
- DIM_W, 12, width of run-time K and M configuration

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- io_start  in  1  start request; sampled only in IDLE
- io_cfgK  in  DIM_W  reduction depth K (rows of weight matrix); latched on accepted start
- io_cfgM  in  DIM_W  output channels M (columns); latched on accepted start
- io_cfgSkew  in  1  skew mode enable; latched on accepted start
- io_ready  in  1  consumer accepts current beat
- io_beatValid  out  1  a beat is presented
- io_rdAddr  out  LANES*ADDR_W  lane j address at bits [j*ADDR_W +: ADDR_W]
- io_addrValid  out  LANES  per-lane valid mask
- io_tileIdx  out  DIM_W  current column tile t
- io_busy  out  1  RUN state
- io_done  out  1  one-cycle completion pulse
- io_cfgErr  out  1  one-cycle pulse on rejected start

## Operation
- Weight matrix layout: row-major K x M bytes; element (k,m) is at address k*M + m.
- Tiles: T = ceil(M/LANES); tile t covers columns t*LANES .. t*LANES+LANES-1. Tiles are issued in order t = 0..T-1.
- Beats per tile: B = K without skew; B = K+LANES-1 with skew. Beat index b runs 0..B-1.
- For lane j at beat b:
  - Row index: k = b - (skew ? j : 0).
  - Column: col = t*LANES + j.
  - Valid iff 0 <= k < K and col < M.
  - Address = k*M + col when valid, else 0.
- States:
  - IDLE -> RUN on io_start=1 with legal config.
  - IDLE -> IDLE with io_cfgErr=1 on illegal config: K=0, M=0, or K*M > 2^ADDR_W.
  - RUN -> DONE when the last beat of tile T-1 is accepted.
  - DONE -> IDLE unconditionally after one cycle.
- A beat is accepted when io_beatValid=1 and io_ready=1. Beat/tile counters advance only on acceptance.
- io_start is ignored in RUN and DONE. K, M and skew stay latched for the whole job.
- An all-zero io_addrValid beat is still presented and must be accepted. This can occur in skew mode when M is not a multiple of LANES.

## Timing
- Reset values: state IDLE, io_beatValid=0, io_rdAddr=0, io_addrValid=0, io_tileIdx=0, io_busy=0, io_done=0, io_cfgErr=0.
- Reset asserted mid-job returns to IDLE immediately with these values. No partial beat persists after reset is released.
- All outputs are registered.
  - Start accepted at edge n: beat (t=0,b=0) and io_busy=1 are visible after edge n.
  - Illegal start at edge n: io_cfgErr=1 for the cycle after edge n.
- Stall: while io_ready=0, io_beatValid, io_rdAddr, io_addrValid and io_tileIdx hold stable.
- Throughput is one beat per cycle with io_ready held high. A job takes T*B cycles from first beat to last accept.
- Last beat accepted at edge n: after edge n, io_beatValid=0, io_busy=0, io_addrValid=0 and io_done=1 for exactly one cycle (DONE). IDLE follows, and a new start is accepted from the following edge.
- io_tileIdx updates together with the first beat of each tile.
- Address arithmetic is unsigned and exact. Legal config guarantees no overflow of ADDR_W.

## Test plan
- K=147, M=64, LANES=16, no skew, ready=1:
  - 588 beats, all masks 0xFFFF.
  - Beat (t=0,b=0) lane j address = j.
  - Beat (t=1,b=2) lane 3 address = 147.
  - Last beat lane 15 address = 9407.
  - io_done pulses one cycle after the last beat.
- K=4, M=20, no skew:
  - 8 beats.
  - Tile 1 mask = 0x000F.
  - Tile 1 beat 3 lane 0 address = 76.
- K=3, M=16, skew:
  - 18 beats.
  - Beat 0: mask 0x0001, lane0 address 0.
  - Beat 2: mask 0x0007, lanes 0,1,2 addresses 32, 17, 2.
  - Beat 17: mask 0x8000, lane15 address 47.
- Backpressure: K=147, M=64, ready toggled pseudo-randomly:
  - Outputs are stable during every stall.
  - The accepted address sequence matches the ready=1 run.
  - Total accepts = 588.
- Illegal config:
  - K=0 start gives io_cfgErr pulse, busy stays 0.
  - K=4095, M=4095 gives io_cfgErr.
  - io_start during RUN is ignored.
- Reset mid-job at beat 100: all outputs are 0 while reset is high. After release, a new start behaves as in the first scenario.
